// File: rtl/ud_seq_pkg.sv
// ----------------------------------------------------------------------------
// ud_seq_pkg
// Shared definitions for the up/down count sequencer:
//   CNT_W      counter / argument width
//   op_e       command opcodes carried on cmd_op
//   state_e    sequencer FSM states
//   at_boundary()  true when the next step in the given direction would cross
//                  the counter range (UP at all-ones, DOWN at zero)
// ----------------------------------------------------------------------------
package ud_seq_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic at_boundary(input cnt_t v, input logic up);
    return up ? (v == '1) : (v == '0);
  endfunction

endpackage

// File: rtl/ud_count_sequencer_if.sv
// ----------------------------------------------------------------------------
// ud_count_sequencer_if
// Command and status bundle of the count sequencer.
//   cmd_valid / cmd_ready  valid/ready handshake; transfer when both high at
//                          a rising clock edge
//   cmd_op, cmd_arg        opcode and load value / step count
//   abort                  terminates a running UP/DOWN
//   q, busy, done, wrap    counter value and status pulses
// Modports:
//   master  command initiator (drives command side, observes status)
//   slave   the sequencer
// ----------------------------------------------------------------------------
interface ud_count_sequencer_if;
  import ud_seq_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd_op;
  cnt_t       cmd_arg;
  logic       cmd_ready;
  logic       abort;
  cnt_t       q;
  logic       busy;
  logic       done;
  logic       wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, abort,
    input  cmd_ready, q, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, abort,
    output cmd_ready, q, busy, done, wrap
  );

endinterface

// File: rtl/ud_count_core.sv
// ----------------------------------------------------------------------------
// ud_count_core
// CNT_W-bit loadable up/down counter with enable. Arithmetic wraps modulo
// 2**CNT_W; range limiting is decided by the controlling FSM.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears q
//   ld    load d into q (has priority over en)
//   en    step q by one
//   u_d   step direction: 1 = up, 0 = down
//   d     load value
//   q     counter value
// ----------------------------------------------------------------------------
module ud_count_core
  import ud_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic en,
  input  logic u_d,
  input  cnt_t d,
  output cnt_t q
);

  // NOTE: clocked state uses non-blocking assignments so every register in
  // the design samples values from before the edge, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= u_d ? q + cnt_t'(1) : q - cnt_t'(1);
    end
  end

endmodule

// File: rtl/ud_count_sequencer.sv
// ----------------------------------------------------------------------------
// ud_count_sequencer
// Accepts LOAD / UP n / DOWN n / NOP commands over a valid/ready handshake and
// drives a ud_count_core through them. Four-state FSM:
//   IDLE  cmd_ready high; a command is latched on the handshake edge
//   LOAD  counter loads the latched argument on the next edge
//   RUN   counter steps once per edge until the remaining count runs out,
//         abort is seen, or (saturating build) a range boundary is hit
//   DONE  one-cycle done pulse, then back to IDLE
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (IDLE, q=0, all pulses low)
//   bus   ud_count_sequencer_if.slave: cmd_valid/cmd_op/cmd_arg/cmd_ready,
//         abort, q, busy, done, wrap
// Build option:
//   UDSEQ_SATURATE_EN  undefined: stepping past 15 or below 0 wraps around,
//                      wrap pulses the cycle after, the run continues.
//                      defined: the boundary step is suppressed, wrap pulses
//                      and the run ends early through DONE.
// ----------------------------------------------------------------------------
module ud_count_sequencer
  import ud_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ud_count_sequencer_if.slave  bus
);

  state_e state, state_nxt;
  op_e    op_r, op_nxt;
  cnt_t   arg_r, arg_nxt;
  cnt_t   rem, rem_nxt;
  logic   wrap_r, wrap_nxt;

  logic   ld, en, u_d;
  logic   hit_bound;
  cnt_t   q_cnt;

  assign u_d       = (op_r == OP_UP);
  assign hit_bound = at_boundary(q_cnt, u_d);

  ud_count_core u_core (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .en  (en),
    .u_d (u_d),
    .d   (arg_r),
    .q   (q_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_r   <= OP_NOP;
      arg_r  <= '0;
      rem    <= '0;
      wrap_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_r   <= op_nxt;
      arg_r  <= arg_nxt;
      rem    <= rem_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here is defaulted first; a branch that
    // forgot one would otherwise infer a latch.
    state_nxt = state;
    op_nxt    = op_r;
    arg_nxt   = arg_r;
    rem_nxt   = rem;
    wrap_nxt  = 1'b0;
    ld        = 1'b0;
    en        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_nxt  = op_e'(bus.cmd_op);
          arg_nxt = bus.cmd_arg;
          case (op_e'(bus.cmd_op))
            OP_LOAD: state_nxt = ST_LOAD;
            OP_UP, OP_DOWN: begin
              if (bus.cmd_arg != '0) begin
                state_nxt = ST_RUN;
                rem_nxt   = bus.cmd_arg;
              end else begin
                state_nxt = ST_DONE;
              end
            end
            default: state_nxt = ST_DONE;   // NOP
          endcase
        end
      end

      ST_LOAD: begin
        ld        = 1'b1;
        state_nxt = ST_DONE;
      end

      ST_RUN: begin
        // Abort wins over everything else: no step on this edge.
        if (bus.abort) begin
          state_nxt = ST_DONE;
          rem_nxt   = '0;
        end
`ifdef UDSEQ_SATURATE_EN
        else if (hit_bound) begin
          // Hold at the range limit and end the run early.
          wrap_nxt  = 1'b1;
          state_nxt = ST_DONE;
          rem_nxt   = '0;
        end
`endif
        else begin
          en       = 1'b1;
          // In the wrapping build the step itself crosses the boundary;
          // the registered flag makes wrap show up the following cycle.
          wrap_nxt = hit_bound;
          rem_nxt  = rem - cnt_t'(1);
          if (rem == cnt_t'(1)) begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.wrap      = wrap_r;
  assign bus.q         = q_cnt;

endmodule

// File: tb/tb_ud_count_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ud_count_sequencer
// Directed bench for ud_count_sequencer. The stimulus process issues commands
// and, for each, queues the q value expected in every busy cycle plus a
// completion record (final q, wrap pulses seen, busy-cycle count). A monitor
// sampling on the falling edge consumes those queues as the DUT reports busy
// and done. Expected values follow UDSEQ_SATURATE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_ud_count_sequencer;
  import ud_seq_pkg::*;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] wraps;
    logic [7:0] lat;
  } done_t;

  logic clk;
  logic rst;

  ud_count_sequencer_if bus ();

  ud_count_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;

  logic [3:0] exp_q[$];
  done_t      exp_done[$];

  int    mon_cyc = 0;
  int    mon_wr  = 0;
  done_t mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Queue n busy-cycle q values (first value in the most significant nibble)
  // and, when with_done is set, the completion record.
  task automatic expect_cmd(input int n, input logic [31:0] trace, input bit with_done,
                            input logic [3:0] fq, input logic [3:0] fw, input logic [7:0] lat);
    done_t d;
    for (int i = 0; i < n; i++) exp_q.push_back(trace[4*(n-1-i) +: 4]);
    if (with_done) begin
      d.q = fq; d.wraps = fw; d.lat = lat;
      exp_done.push_back(d);
    end
  endtask

  // Called #1 after a rising edge. Holds cmd_valid until the handshake edge
  // and returns #1 after it; waits reports the cycles spent held off.
  task automatic issue(input op_e op, input logic [3:0] arg, output int waits);
    waits = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    while (!bus.cmd_ready) begin
      @(posedge clk); #1;
      waits++;
      if (waits > 40) begin
        fail("cmd_ready_timeout");
        finish_run();
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_arg   = '0;
  endtask

  // Monitor: consumes expectations whenever the DUT is busy / signals done.
  always @(negedge clk) begin
    if (rst) begin
      mon_cyc = 0;
      mon_wr  = 0;
    end else if (bus.busy) begin
      mon_cyc++;
      if (bus.wrap) mon_wr++;
      check("ready_low_busy", bus.cmd_ready, 0);
      if (exp_q.size() == 0) fail("unexpected_busy_cycle");
      else check("q_trace", bus.q, exp_q.pop_front());
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          fail("unexpected_done");
        end else begin
          mon_e = exp_done.pop_front();
          check("done_q", bus.q, mon_e.q);
          check("wrap_count", mon_wr, mon_e.wraps);
          check("busy_cycles", mon_cyc, mon_e.lat);
        end
        mon_cyc = 0;
        mon_wr  = 0;
      end
    end else begin
      check("ready_high_idle", bus.cmd_ready, 1);
      check("wrap_low_idle", bus.wrap, 0);
    end
  end

  initial begin
    int w;
    logic [3:0] pq;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_arg   = '0;
    bus.abort     = 1'b0;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_q", bus.q, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wrap", bus.wrap, 0);
    rst = 1'b0;

    // LOAD 9 straight out of reset: accepted on the first edge.
    expect_cmd(2, 'h09, 1, 4'd9, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd9, w);
    check("first_cmd_no_wait", w, 0);

    // LOAD 3 is offered while busy and must be held off, not dropped.
    expect_cmd(2, 'h93, 1, 4'd3, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd3, w);
    check("holdoff_cycles", w, 2);

    expect_cmd(5, 'h34567, 1, 4'd7, 4'd0, 8'd5);
    issue(OP_UP, 4'd4, w);

    expect_cmd(2, 'h7E, 1, 4'd14, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd14, w);

`ifdef UDSEQ_SATURATE_EN
    expect_cmd(3, 'hEFF, 1, 4'd15, 4'd1, 8'd3);
    pq = 4'd15;
`else
    expect_cmd(4, 'hEF01, 1, 4'd1, 4'd1, 8'd4);
    pq = 4'd1;
`endif
    issue(OP_UP, 4'd3, w);

    // LOAD 2, DOWN 5 with abort during the third RUN cycle.
    expect_cmd(2, {24'h0, pq, 4'h2}, 1, 4'd2, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd2, w);
    expect_cmd(4, 'h2100, 1, 4'd0, 4'd0, 8'd4);
    issue(OP_DOWN, 4'd5, w);
    repeat (2) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;

    // abort outside RUN has no effect on a LOAD.
    bus.abort = 1'b1;
    expect_cmd(2, 'h06, 1, 4'd6, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd6, w);
    @(posedge clk);
    #1 bus.abort = 1'b0;

    // DOWN across zero.
    expect_cmd(2, 'h61, 1, 4'd1, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd1, w);
`ifdef UDSEQ_SATURATE_EN
    expect_cmd(3, 'h100, 1, 4'd0, 4'd1, 8'd3);
    pq = 4'd0;
`else
    expect_cmd(4, 'h10FE, 1, 4'd14, 4'd1, 8'd4);
    pq = 4'd14;
`endif
    issue(OP_DOWN, 4'd3, w);

    // UP n=0 and NOP: straight to DONE, q unchanged.
    expect_cmd(1, {28'h0, pq}, 1, pq, 4'd0, 8'd1);
    issue(OP_UP, 4'd0, w);
    expect_cmd(1, {28'h0, pq}, 1, pq, 4'd0, 8'd1);
    issue(OP_NOP, 4'd5, w);

    // rst in the middle of UP 8: run discarded, no done pulse.
    expect_cmd(2, {24'h0, pq, 4'h5}, 1, 4'd5, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd5, w);
    expect_cmd(2, 'h56, 0, 4'd0, 4'd0, 8'd0);
    issue(OP_UP, 4'd8, w);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_q", bus.q, 0);
    check("midrun_rst_ready", bus.cmd_ready, 1);
    check("midrun_rst_busy", bus.busy, 0);
    check("midrun_rst_done", bus.done, 0);
    check("midrun_trace_used", exp_q.size(), 0);
    check("midrun_no_pending_done", exp_done.size(), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    expect_cmd(2, 'h0A, 1, 4'd10, 4'd0, 8'd2);
    issue(OP_LOAD, 4'd10, w);
    check("post_rst_no_wait", w, 0);

    // Drain: everything queued must be consumed.
    w = 0;
    while (bus.busy || exp_done.size() != 0) begin
      @(posedge clk); #1;
      w++;
      if (w > 40) begin
        fail("drain_timeout");
        finish_run();
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("trace_drained", exp_q.size(), 0);
    check("done_drained", exp_done.size(), 0);
    finish_run();
  end

endmodule
